// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  // Width of the little-endian word-count header.
  localparam int HDR_W = 16;

  // Loader states; 3-bit encodings.
  typedef enum logic [2:0] {
    S_HDR_LO = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // True in the states that take bytes from the stream.
  function automatic logic accepting(input state_t s);
    return (s == S_HDR_LO) || (s == S_HDR_HI) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four little-endian stream bytes into one 32-bit instruction word.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word
);

  logic [23:0] buffer;
  logic [1:0]  byte_idx;

  // The fourth byte is not buffered: it is merged straight into the word.
  assign word_done = en && (byte_idx == 2'd3);
  assign word      = {byte_data, buffer};

  // Store bytes 0..2 in their lanes; the index wraps to 0 after byte 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer   <= '0;
      byte_idx <= '0;
    end else if (clr) begin
      byte_idx <= '0;
    end else if (en) begin
      case (byte_idx)
        2'd0:    buffer[7:0]   <= byte_data;
        2'd1:    buffer[15:8]  <= byte_data;
        2'd2:    buffer[23:16] <= byte_data;
        default: ;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted byte stream, writes instruction memory,
// and releases the CPU only after the last word has been committed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic          load_req,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_start,
  output logic          done,
  output logic          err
);

  localparam logic [HDR_W-1:0] DEPTH_W = HDR_W'(DEPTH);

  state_t           state;
  logic [HDR_W-1:0] count;
  logic [HDR_W-1:0] word_idx;
  logic [HDR_W-1:0] hdr;
  logic             fire;
  logic             asm_en;
  logic             asm_clr;
  logic             word_done;
  logic [31:0]      word;

  assign fire    = byte_valid && byte_ready;
  assign asm_en  = fire && (state == S_DATA);
  assign asm_clr = fire && (state == S_HDR_HI);
  assign hdr     = {byte_data, count[7:0]};

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .en        (asm_en),
    .byte_data (byte_data),
    .word_done (word_done),
    .word      (word)
  );

  // Load sequencer; byte_ready tracks the accepting-ness of the next state,
  // cpu_start/done/err lag the state by one edge so the last write lands first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_HDR_LO;
      count      <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_start  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      byte_ready <= accepting(state);
      cpu_start  <= (state == S_DONE);
      done       <= (state == S_DONE);
      err        <= (state == S_ERR);
      case (state)
        S_HDR_LO: begin
          if (fire) begin
            count[7:0] <= byte_data;
            state      <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (fire) begin
            count[15:8] <= byte_data;
            word_idx    <= '0;
            if (hdr == '0) begin
              state      <= S_DONE;
              byte_ready <= 1'b0;
            end else if (hdr > DEPTH_W) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_done) begin
            imem_we    <= 1'b1;
            imem_waddr <= word_idx[AW-1:0];
            imem_wdata <= word;
            word_idx   <= word_idx + 16'd1;
            if (word_idx == count - 16'd1) begin
              state      <= S_DONE;
              byte_ready <= 1'b0;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (load_req) begin
            state      <= S_HDR_LO;
            byte_ready <= 1'b1;
            cpu_start  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        default: begin
          state      <= S_HDR_LO;
          byte_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
